// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one 16-bit asynchronous SRAM between the IF stage (read-only) and the MEM stage
//   (load/store). Every 32-bit access is two 16-bit beats, low half first. Each beat is held on
//   the pins for WAIT_CYCLES+1 cycles. The FSM sequence is IDLE -> LO -> HI -> DONE -> IDLE.
//
// Parameters
//   ADDR_W       SRAM half-word address width (must be > 15)
//   WAIT_CYCLES  extra cycles each beat is held on the pins
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   if_req/if_addr             IF read request and byte address
//   if_rdata/if_ready          IF read data and one-cycle completion pulse
//   if_stall                   if_req & ~if_ready
//   mem_rd/mem_wr/mem_addr     MEM request and byte address (rd&wr counts as a write)
//   mem_wdata                  MEM write data
//   mem_rdata/mem_ready        MEM read data and one-cycle completion pulse
//   mem_stall                  (mem_rd|mem_wr) & ~mem_ready
//   SRAMaddress/SRAMWEn        SRAM half-word address, active-low write enable
//   SRAMdata                   SRAM data bus, driven only during write beats
//
// Build option
//   ARB_RR_EN  when defined, round-robin arbitration replaces fixed MEM-over-IF priority.

module sram_port_arbiter #(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [15:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    output logic              if_stall,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [15:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic              mem_stall,
    output logic [ADDR_W-1:0] SRAMaddress,
    output logic              SRAMWEn,
    inout  wire  [15:0]       SRAMdata
);

    localparam int unsigned BEAT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned PAD_W  = ADDR_W - 15;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WAIT_CYCLES);
    // Only consulted when WAIT_CYCLES > 0; marks the cycle before the last one of a beat.
    localparam logic [BEAT_W-1:0] BEAT_PRE  = BEAT_W'(WAIT_CYCLES - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

    typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_t;

    state_t              r_state;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_port_mem;
    logic                r_write;
    logic [13:0]         r_wa;
    logic [31:0]         r_wdata;
    logic [15:0]         r_lo;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic                r_drive;
    logic [15:0]         r_dout;
    logic [31:0]         r_if_rdata;
    logic [31:0]         r_mem_rdata;
    logic                r_if_ready;
    logic                r_mem_ready;

    logic                w_mem_req;
    logic                w_grant_any;
    logic                w_grant_mem;
    logic                w_grant_wr;
    logic [13:0]         w_sel_wa;
    logic                w_last;
    logic                w_next_last;
    logic                w_unused;

    assign w_mem_req   = mem_rd | mem_wr;
    assign w_grant_any = w_mem_req | if_req;

`ifdef ARB_RR_EN
    // Pointer set means MEM is preferred; a lone requester wins regardless.
    logic r_rr_mem;
    assign w_grant_mem = w_mem_req & (~if_req | r_rr_mem);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_mem <= 1'b0;
        end else if (r_state == StIdle && w_grant_any) begin
            r_rr_mem <= ~w_grant_mem;
        end
    end
`else
    assign w_grant_mem = w_mem_req;
`endif

    assign w_grant_wr  = w_grant_mem & mem_wr;
    assign w_sel_wa    = w_grant_mem ? mem_addr[15:2] : if_addr[15:2];
    assign w_last      = (r_beat == BEAT_LAST);
    assign w_next_last = (r_beat == BEAT_PRE);
    assign w_unused    = ^{if_addr[1:0], mem_addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_beat      <= '0;
            r_port_mem  <= 1'b0;
            r_write     <= 1'b0;
            r_wa        <= '0;
            r_wdata     <= '0;
            r_lo        <= '0;
            r_addr      <= '0;
            r_wen       <= 1'b1;
            r_drive     <= 1'b0;
            r_dout      <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_grant_any) begin
                        r_port_mem <= w_grant_mem;
                        r_write    <= w_grant_wr;
                        r_wa       <= w_sel_wa;
                        r_wdata    <= mem_wdata;
                        r_addr     <= {{PAD_W{1'b0}}, w_sel_wa, 1'b0};
                        r_beat     <= '0;
                        // First cycle of a write beat always has WEn low.
                        r_wen      <= ~w_grant_wr;
                        r_drive    <= w_grant_wr;
                        r_dout     <= mem_wdata[15:0];
                        r_state    <= StLo;
                    end
                end
                StLo, StHi: begin
                    if (w_last) begin
                        r_beat <= '0;
                        if (r_state == StLo) begin
                            if (!r_write) begin
                                r_lo <= SRAMdata;
                            end
                            r_addr  <= {{PAD_W{1'b0}}, r_wa, 1'b1};
                            r_dout  <= r_wdata[31:16];
                            r_wen   <= ~r_write;
                            r_state <= StHi;
                        end else begin
                            r_wen   <= 1'b1;
                            r_drive <= 1'b0;
                            if (r_port_mem) begin
                                r_mem_ready <= 1'b1;
                                if (!r_write) begin
                                    r_mem_rdata <= {SRAMdata, r_lo};
                                end
                            end else begin
                                r_if_ready <= 1'b1;
                                r_if_rdata <= {SRAMdata, r_lo};
                            end
                            r_state <= StDone;
                        end
                    end else begin
                        r_beat <= r_beat + BEAT_ONE;
                        // Raise WEn for the last cycle of a write beat: data stays driven (hold).
                        r_wen  <= ~r_write | w_next_last;
                    end
                end
                StDone: begin
                    r_if_ready  <= 1'b0;
                    r_mem_ready <= 1'b0;
                    r_state     <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign SRAMdata    = r_drive ? r_dout : 16'hzzzz;
    assign SRAMaddress = r_addr;
    assign SRAMWEn     = r_wen;
    assign if_rdata    = r_if_rdata;
    assign mem_rdata   = r_mem_rdata;
    assign if_ready    = r_if_ready;
    assign mem_ready   = r_mem_ready;
    assign if_stall    = if_req & ~r_if_ready;
    assign mem_stall   = w_mem_req & ~r_mem_ready;

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

    localparam int unsigned ADDR_W = 18;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [15:0]       if_addr;
    logic [31:0]       if_rdata;
    logic              if_ready;
    logic              if_stall;
    logic              mem_rd;
    logic              mem_wr;
    logic [15:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic              mem_stall;
    logic [ADDR_W-1:0] SRAMaddress;
    logic              SRAMWEn;
    wire  [15:0]       SRAMdata;

    sram_port_arbiter #(.ADDR_W(ADDR_W), .WAIT_CYCLES(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ready   (if_ready),
        .if_stall   (if_stall),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .mem_stall  (mem_stall),
        .SRAMaddress(SRAMaddress),
        .SRAMWEn    (SRAMWEn),
        .SRAMdata   (SRAMdata)
    );

    always #5 clk = ~clk;

    // SRAM model: drives the bus only for reads the bench has announced.
    logic [15:0] sram [0:32767];
    logic        model_oe;
    assign SRAMdata = (model_oe && SRAMWEn) ? sram[SRAMaddress[14:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (SRAMWEn === 1'b0) sram[SRAMaddress[14:0]] <= SRAMdata;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard of completed accesses, in expected completion order.
    typedef struct {
        bit          is_mem;
        logic [31:0] rdata;
    } sb_t;
    sb_t sbq[$];
    sb_t sb_e;
    logic if_ready_prev = 1'b0;
    logic mem_ready_prev = 1'b0;

    task automatic sb_push(input bit is_mem, input logic [31:0] rdata);
        sb_t e;
        e.is_mem = is_mem;
        e.rdata  = rdata;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && (if_ready || mem_ready)) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_ready", {30'b0, mem_ready, if_ready}, 32'd0);
            end else begin
                sb_e = sbq.pop_front();
                chk("sb_port", {31'b0, mem_ready}, {31'b0, sb_e.is_mem});
                chk("sb_rdata", mem_ready ? mem_rdata : if_rdata, sb_e.rdata);
                chk("ready_pulse_1cyc", {30'b0, mem_ready_prev & mem_ready, if_ready_prev & if_ready},
                    32'd0);
            end
        end
        if_ready_prev  <= if_ready;
        mem_ready_prev <= mem_ready;
    end

    // One access from IDLE; checks pins per cycle, latency and stall.
    task automatic do_access(input bit is_mem, input bit wr, input bit both,
                             input logic [15:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp);
        logic [ADDR_W-1:0] lo;
        bit                w;
        bit                done;
        int                k;
        w  = wr | both;
        lo = {{(ADDR_W-15){1'b0}}, addr[15:2], 1'b0};
        @(negedge clk);
        sb_push(is_mem, exp);
        model_oe = !w;
        if (is_mem) begin
            mem_addr  = addr;
            mem_wdata = wdata;
            mem_rd    = !wr || both;
            mem_wr    = w;
        end else begin
            if_addr = addr;
            if_req  = 1'b1;
        end
        #1 chk("stall_on_req", {31'b0, is_mem ? mem_stall : if_stall}, 32'd1);
        k    = 0;
        done = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
            if (k <= 4) begin
                chk("sram_addr", 32'(SRAMaddress), 32'(k <= 2 ? lo : (lo | 1)));
                chk("sram_wen", {31'b0, SRAMWEn}, {31'b0, !(w && (k % 2 == 1))});
            end
            if (is_mem ? mem_ready : if_ready) begin
                done = 1;
                chk("latency", 32'(k), 32'd5);
                if (is_mem) begin
                    mem_rd = 1'b0;
                    mem_wr = 1'b0;
                end else begin
                    if_req = 1'b0;
                end
            end
        end
        if (!done) chk("access_timeout", 32'(k), 32'd5);
    endtask

    typedef struct {
        bit          is_mem;
        bit          wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[8];

    int          times[3];
    int          n_rdy;
    int          cyc;
    bit          got_m;
    bit          got_i;

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b1; if_req = 0; if_addr = 0; mem_rd = 0; mem_wr = 0; mem_addr = 0; mem_wdata = 0;
        model_oe = 1'b0;
        for (int i = 0; i < 32768; i++) sram[i] = 16'h0;
        sram[8] = 16'h5678;      sram[9] = 16'h1234;
        sram[16'h7ffe] = 16'hCAFE; sram[16'h7fff] = 16'hF00D;
        for (int i = 0; i < 6; i++) sram[i] = 16'h1111 * 16'(i + 1);

        vecs[0] = '{0, 0, 16'h0010, 32'h0,         32'h12345678};
        vecs[1] = '{1, 1, 16'h0020, 32'hDEADBEEF,  32'h00000000};
        vecs[2] = '{0, 0, 16'h0020, 32'h0,         32'hDEADBEEF};
        vecs[3] = '{1, 0, 16'h0010, 32'h0,         32'h12345678};
        vecs[4] = '{1, 1, 16'h0104, 32'h0BADF00D,  32'h12345678};
        vecs[5] = '{1, 0, 16'h0107, 32'h0,         32'h0BADF00D};
        vecs[6] = '{0, 0, 16'h0104, 32'h0,         32'h0BADF00D};
        vecs[7] = '{0, 0, 16'hFFFC, 32'h0,         32'hF00DCAFE};

        repeat (3) @(negedge clk);
        chk("rst_wen", {31'b0, SRAMWEn}, 32'd1);
        chk("rst_addr", 32'(SRAMAddress_w()), 32'd0);
        chk("rst_ready", {30'b0, mem_ready, if_ready}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_stall", {30'b0, mem_stall, if_stall}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_access(vecs[i].is_mem, vecs[i].wr, 1'b0, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
        end
        chk("sram16", {16'h0, sram[16]}, 32'h0000BEEF);
        chk("sram17", {16'h0, sram[17]}, 32'h0000DEAD);
        chk("if_rdata_hold", if_rdata, 32'hF00DCAFE);

        // rd&wr together is a write; mem_rdata keeps the last read value.
        do_access(1'b1, 1'b0, 1'b1, 16'h0030, 32'hA5A55A5A, 32'h0BADF00D);
        do_access(1'b0, 1'b0, 1'b0, 16'h0030, 32'h0, 32'hA5A55A5A);

        // Contention: MEM must complete before IF.
        @(negedge clk);
        model_oe = 1'b1;
        sb_push(1'b1, 32'h12345678);
        sb_push(1'b0, 32'hDEADBEEF);
        mem_addr = 16'h0010; mem_rd = 1'b1;
        if_addr  = 16'h0020; if_req = 1'b1;
        got_m = 0; got_i = 0; cyc = 0;
        while (!(got_m && got_i) && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mem_ready) begin mem_rd = 1'b0; got_m = 1; end
            if (if_ready)  begin if_req = 1'b0; got_i = 1; end
        end
        chk("contention_done", {30'b0, got_m, got_i}, 32'd3);

        // IF held for three back-to-back accesses.
        @(negedge clk);
        model_oe = 1'b1;
        sb_push(1'b0, 32'h22221111);
        sb_push(1'b0, 32'h44443333);
        sb_push(1'b0, 32'h66665555);
        if_addr = 16'h0000; if_req = 1'b1;
        n_rdy = 0; cyc = 0;
        while (n_rdy < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (if_ready) begin
                times[n_rdy] = cyc;
                n_rdy++;
                if (n_rdy < 3) if_addr = 16'(n_rdy * 4);
                else           if_req  = 1'b0;
            end
        end
        chk("b2b_count", 32'(n_rdy), 32'd3);
        if (n_rdy == 3) begin
            chk("b2b_gap0", 32'(times[1] - times[0]), 32'd6);
            chk("b2b_gap1", 32'(times[2] - times[1]), 32'd6);
        end
        chk("b2b_mem_rdata", mem_rdata, 32'h12345678);

        // Reset during the HI beat of a write.
        @(negedge clk);
        model_oe = 1'b0;
        mem_addr = 16'h0040; mem_wdata = 32'h11112222; mem_wr = 1'b1;
        repeat (3) @(negedge clk);
        chk("hi_beat_wen_low", {31'b0, SRAMWEn}, 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst_wen", {31'b0, SRAMWEn}, 32'd1);
        chk("midrst_ready", {30'b0, mem_ready, if_ready}, 32'd0);
        @(negedge clk);
        mem_wr = 1'b0;
        rst = 1'b0;
        n_rdy = 0;
        repeat (8) begin
            @(negedge clk);
            if (mem_ready || if_ready) n_rdy++;
        end
        chk("midrst_no_ready", 32'(n_rdy), 32'd0);
        chk("midrst_mem_rdata", mem_rdata, 32'd0);
        do_access(1'b0, 1'b0, 1'b0, 16'h0010, 32'h0, 32'h12345678);

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    function automatic logic [ADDR_W-1:0] SRAMAddress_w();
        return SRAMaddress;
    endfunction

endmodule
